fu_fadd: RTL and testbench

FU_FADD -- requirements
Module: fu_fadd

---
 rtl/fpu_pkg.sv | 35 +++
 rtl/fpu_lzc24.sv | 15 +
 rtl/fu_fadd.sv | 231 +++++++++++++++++++++++
 tb/tb_fu_fadd.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_pkg.sv
// Shared single-precision FPU definitions: exponent constants, canonical NaN,
// exception flag bit positions, multi-cycle unit state encoding and helpers.
package fpu_pkg;

  localparam int unsigned EXP_BIAS = 127;
  localparam logic [7:0]  EXP_MAX  = 8'(2 * EXP_BIAS + 1);
  localparam logic [31:0] QNAN     = 32'h7FC00000;

  localparam int unsigned FLAG_NV = 4;
  localparam int unsigned FLAG_DZ = 3;
  localparam int unsigned FLAG_OF = 2;
  localparam int unsigned FLAG_UF = 1;
  localparam int unsigned FLAG_NX = 0;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ALIGN = 3'd1,
    NORM  = 3'd2,
    ROUND = 3'd3,
    DONE  = 3'd4
  } fadd_state_e;

  function automatic logic fp_is_nan(input logic [31:0] x);
    return (x[30:23] == EXP_MAX) && (x[22:0] != 23'h0);
  endfunction

  function automatic logic fp_is_inf(input logic [31:0] x);
    return (x[30:23] == EXP_MAX) && (x[22:0] == 23'h0);
  endfunction

  function automatic logic fp_is_snan(input logic [31:0] x);
    return fp_is_nan(x) && !x[22];
  endfunction

endpackage

// File: rtl/fpu_lzc24.sv
// Combinational 24-bit leading-zero counter; an all-zero input counts as 24.
module fpu_lzc24 (
  input  logic [23:0] din_i,
  output logic [4:0]  cnt_o
);

  // Scan upward so the most significant set bit is the last to assign.
  always_comb begin
    cnt_o = 5'd24;
    for (int i = 0; i < 24; i++) begin
      if (din_i[i]) cnt_o = 5'(23 - i);
    end
  end

endmodule

// File: rtl/fu_fadd.sv
// Multi-cycle IEEE-754 single adder/subtractor (RNE, flush-to-zero), fixed 4-edge latency.
// Define FU_FADD_FLAGS_EN to compute exception flags and expose the fflags port.
module fu_fadd
  import fpu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        EN,
  input  logic        sub,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        finish,
  output logic [31:0] res,
  output logic        busy
`ifdef FU_FADD_FLAGS_EN
  ,
  output logic [4:0]  fflags
`endif
);

  fadd_state_e state_q, state_d;
  logic        accept;

  assign accept = EN && ((state_q == IDLE) || (state_q == DONE));

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = ALIGN;
      ALIGN:   state_d = NORM;
      NORM:    state_d = ROUND;
      ROUND:   state_d = DONE;
      DONE:    state_d = accept ? ALIGN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q != IDLE);
  end

  logic [31:0] a_q, b_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q <= 32'h0;
      b_q <= 32'h0;
    end else if (accept) begin
      a_q <= A;
      b_q <= {B[31] ^ sub, B[30:0]};
    end
  end

  logic        a_nan, b_nan, a_inf, b_inf, inf_sub_inf, spec_d;
  logic [31:0] spec_res_d;
  logic [30:0] a_mag, b_mag, big_mag, small_mag;
  logic        swap, big_sign, small_sign, eff_sub;
  logic [23:0] big_sig, small_sig;
  logic [7:0]  exp_diff;
  logic [4:0]  shamt;
  logic [51:0] small_ext;
  logic [27:0] op_big, op_small, sum_d;

  // Subnormal operands collapse to signed zero before the magnitude compare.
  always_comb begin
    a_nan       = fp_is_nan(a_q);
    b_nan       = fp_is_nan(b_q);
    a_inf       = fp_is_inf(a_q);
    b_inf       = fp_is_inf(b_q);
    inf_sub_inf = a_inf && b_inf && (a_q[31] != b_q[31]);
    spec_d      = a_nan || b_nan || a_inf || b_inf;
    if (a_nan || b_nan || inf_sub_inf) spec_res_d = QNAN;
    else if (a_inf)                    spec_res_d = {a_q[31], EXP_MAX, 23'h0};
    else                               spec_res_d = {b_q[31], EXP_MAX, 23'h0};

    a_mag      = (a_q[30:23] == 8'h00) ? 31'h0 : a_q[30:0];
    b_mag      = (b_q[30:23] == 8'h00) ? 31'h0 : b_q[30:0];
    swap       = (b_mag > a_mag);
    big_mag    = swap ? b_mag : a_mag;
    small_mag  = swap ? a_mag : b_mag;
    big_sign   = swap ? b_q[31] : a_q[31];
    small_sign = swap ? a_q[31] : b_q[31];
    eff_sub    = big_sign ^ small_sign;
    big_sig    = {|big_mag[30:23], big_mag[22:0]};
    small_sig  = {|small_mag[30:23], small_mag[22:0]};
    exp_diff   = big_mag[30:23] - small_mag[30:23];
    shamt      = (exp_diff > 8'd26) ? 5'd26 : exp_diff[4:0];
    small_ext  = {small_sig, 28'h0} >> shamt;
    // Layout: [27] carry, [26:3] significand, [2] guard, [1] round, [0] sticky.
    op_big     = {1'b0, big_sig, 3'b000};
    op_small   = {1'b0, small_ext[51:26], |small_ext[25:0]};
    sum_d      = eff_sub ? (op_big - op_small) : (op_big + op_small);
  end

  logic [27:0] sum_q;
  logic [7:0]  exp1_q;
  logic        sign1_q, eff_sub_q, spec_q;
  logic [31:0] spec_res_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q      <= 28'h0;
      exp1_q     <= 8'h0;
      sign1_q    <= 1'b0;
      eff_sub_q  <= 1'b0;
      spec_q     <= 1'b0;
      spec_res_q <= 32'h0;
    end else if (state_q == ALIGN) begin
      sum_q      <= sum_d;
      exp1_q     <= big_mag[30:23];
      sign1_q    <= big_sign;
      eff_sub_q  <= eff_sub;
      spec_q     <= spec_d;
      spec_res_q <= spec_res_d;
    end
  end

  logic [4:0]        lzc;
  logic [26:0]       norm_m_d;
  logic signed [9:0] norm_e_d;
  logic              norm_zero_d, norm_sign_d;

  fpu_lzc24 u_lzc (
    .din_i (sum_q[26:3]),
    .cnt_o (lzc)
  );

  // An exact zero from opposite-sign operands is +0; like-signed zeros keep their sign.
  always_comb begin
    if (sum_q[27]) begin
      norm_m_d = {sum_q[27:2], |sum_q[1:0]};
      norm_e_d = $signed({2'b00, exp1_q}) + 10'sd1;
    end else begin
      norm_m_d = sum_q[26:0] << lzc;
      norm_e_d = $signed({2'b00, exp1_q}) - $signed({5'b00000, lzc});
    end
    norm_zero_d = (sum_q == 28'h0);
    norm_sign_d = norm_zero_d ? (sign1_q & ~eff_sub_q) : sign1_q;
  end

  logic [26:0]       m_q;
  logic signed [9:0] e_q;
  logic              sign2_q, zero2_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      m_q     <= 27'h0;
      e_q     <= 10'sd0;
      sign2_q <= 1'b0;
      zero2_q <= 1'b0;
    end else if (state_q == NORM) begin
      m_q     <= norm_m_d;
      e_q     <= norm_e_d;
      sign2_q <= norm_sign_d;
      zero2_q <= norm_zero_d;
    end
  end

  logic              round_up, ovf, unf;
  logic [24:0]       rounded;
  logic [22:0]       frac_f;
  logic signed [9:0] exp_f;
  logic [31:0]       res_d;

  always_comb begin
    round_up = m_q[2] & (m_q[1] | m_q[0] | m_q[3]);
    rounded  = {1'b0, m_q[26:3]} + {24'h0, round_up};
    if (rounded[24]) begin
      frac_f = rounded[23:1];
      exp_f  = e_q + 10'sd1;
    end else begin
      frac_f = rounded[22:0];
      exp_f  = e_q;
    end
    ovf = !spec_q && !zero2_q && (exp_f >= $signed({2'b00, EXP_MAX}));
    unf = !spec_q && !zero2_q && !ovf && (exp_f <= 10'sd0);

    res_d = {sign2_q, exp_f[7:0], frac_f};
    if (spec_q)                res_d = spec_res_q;
    else if (zero2_q || unf)   res_d = {sign2_q, 31'h0};
    else if (ovf)              res_d = {sign2_q, EXP_MAX, 23'h0};
  end

  logic        finish_q;
  logic [31:0] res_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      finish_q <= 1'b0;
      res_q    <= 32'h0;
    end else begin
      finish_q <= (state_q == ROUND);
      if (state_q == ROUND) res_q <= res_d;
    end
  end

  assign finish = finish_q;
  assign res    = res_q;

`ifdef FU_FADD_FLAGS_EN
  logic       spec_nv_q;
  logic [4:0] flags_d, flags_q;

  always_ff @(posedge clk) begin
    if (rst)                    spec_nv_q <= 1'b0;
    else if (state_q == ALIGN)  spec_nv_q <= fp_is_snan(a_q) || fp_is_snan(b_q) || inf_sub_inf;
  end

  always_comb begin
    flags_d          = 5'h0;
    flags_d[FLAG_NV] = spec_q && spec_nv_q;
    flags_d[FLAG_DZ] = 1'b0;
    flags_d[FLAG_OF] = ovf;
    flags_d[FLAG_UF] = unf;
    flags_d[FLAG_NX] = ovf || unf || (!spec_q && !zero2_q && (|m_q[2:0]));
  end

  always_ff @(posedge clk) begin
    if (rst)                    flags_q <= 5'h0;
    else if (state_q == ROUND)  flags_q <= flags_d;
  end

  assign fflags = flags_q;
`endif

endmodule

// File: tb/tb_fu_fadd.sv
// Scoreboard bench for fu_fadd: directed vectors, back-to-back issue, ignored EN,
// mid-operation reset and reset/EN priority.
module tb_fu_fadd;

  logic        clk = 1'b0;
  logic        rst, EN, sub;
  logic [31:0] A, B;
  logic        finish, busy;
  logic [31:0] res;
`ifdef FU_FADD_FLAGS_EN
  logic [4:0]  fflags;
`endif

  always #5 clk = ~clk;

  fu_fadd dut (
    .clk    (clk),
    .rst    (rst),
    .EN     (EN),
    .sub    (sub),
    .A      (A),
    .B      (B),
    .finish (finish),
    .res    (res),
    .busy   (busy)
`ifdef FU_FADD_FLAGS_EN
    ,
    .fflags (fflags)
`endif
  );

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic        s;
    logic [31:0] r;
    logic [4:0]  f;
  } vec_t;

  typedef struct {
    logic [31:0] r;
    logic [4:0]  f;
    int          cyc;
    int          id;
  } exp_t;

  localparam int NVEC = 20;
  vec_t vecs [0:NVEC-1] = '{
    '{32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 5'h00},
    '{32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 5'h00},
    '{32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 5'h05},
    '{32'h7F800000, 32'hFF800000, 1'b0, 32'h7FC00000, 5'h10},
    '{32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 5'h01},
    '{32'h3F800001, 32'h33800000, 1'b0, 32'h3F800002, 5'h01},
    '{32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 5'h00},
    '{32'h7F800000, 32'h3F800000, 1'b0, 32'h7F800000, 5'h00},
    '{32'h7FC00000, 32'h3F800000, 1'b0, 32'h7FC00000, 5'h00},
    '{32'h7F800001, 32'h00000000, 1'b0, 32'h7FC00000, 5'h10},
    '{32'h40400000, 32'h3F800000, 1'b1, 32'h40000000, 5'h00},
    '{32'h00400000, 32'h3F800000, 1'b0, 32'h3F800000, 5'h00},
    '{32'h00800000, 32'h00C00000, 1'b1, 32'h80000000, 5'h03},
    '{32'hBF800000, 32'h3F800000, 1'b0, 32'h00000000, 5'h00},
    '{32'h3F800000, 32'h80000000, 1'b0, 32'h3F800000, 5'h00},
    '{32'h3F800000, 32'h33C00000, 1'b0, 32'h3F800001, 5'h01},
    '{32'h4B7FFFFF, 32'h3F000000, 1'b0, 32'h4B800000, 5'h01},
    '{32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, 5'h10},
    '{32'hFF800000, 32'h3F800000, 1'b0, 32'hFF800000, 5'h00},
    '{32'h3F800000, 32'hBF800000, 1'b1, 32'h40000000, 5'h00}
  };

  exp_t sb_q [$];
  exp_t e_pop;
  int   n_cmp = 0;
  int   n_err = 0;
  int   n_exp = 0;
  int   n_fin = 0;
  int   cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", tag, got, want);
    end
  endtask

  task automatic push_exp(input logic [31:0] r, input logic [4:0] f, input int c);
    exp_t e;
    e.r   = r;
    e.f   = f;
    e.cyc = c;
    e.id  = n_exp;
    sb_q.push_back(e);
    n_exp++;
  endtask

  // Returns one negedge after the accepting edge, with EN dropped.
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic s);
    @(negedge clk);
    A   = a;
    B   = b;
    sub = s;
    EN  = 1'b1;
    @(negedge clk);
    EN  = 1'b0;
  endtask

  task automatic drain();
    int k = 0;
    while (sb_q.size() != 0 && k < 40) begin
      @(negedge clk);
      k++;
    end
    check_eq("drain", 32'(sb_q.size()), 32'h0);
  endtask

  always @(negedge clk) begin
    if (!rst && finish) begin
      n_fin++;
      if (sb_q.size() == 0) begin
        check_eq("spurious_finish", 32'(finish), 32'h0);
      end else begin
        e_pop = sb_q.pop_front();
        check_eq($sformatf("op%0d_res", e_pop.id), res, e_pop.r);
        check_eq($sformatf("op%0d_latency", e_pop.id), 32'(cyc - e_pop.cyc), 32'd3);
`ifdef FU_FADD_FLAGS_EN
        check_eq($sformatf("op%0d_fflags", e_pop.id), 32'(fflags), 32'(e_pop.f));
`endif
        $display("op%0d done: res=%08h want=%08h at cycle %0d", e_pop.id, res, e_pop.r, cyc);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached with %0d ops outstanding", sb_q.size());
    $fatal(1, "watchdog");
  end

  initial begin
    int fin0;
    int c0;
    rst = 1'b1;
    EN  = 1'b0;
    sub = 1'b0;
    A   = 32'h0;
    B   = 32'h0;
    repeat (3) @(negedge clk);
    check_eq("reset_busy", 32'(busy), 32'h0);
    check_eq("reset_finish", 32'(finish), 32'h0);
    check_eq("reset_res", res, 32'h0);
`ifdef FU_FADD_FLAGS_EN
    check_eq("reset_fflags", 32'(fflags), 32'h0);
`endif
    rst = 1'b0;

    // Back-to-back: each new EN lands in the DONE cycle of the previous op.
    for (int i = 0; i < NVEC; i++) begin
      issue(vecs[i].a, vecs[i].b, vecs[i].s);
      push_exp(vecs[i].r, vecs[i].f, cyc);
      repeat (2) @(negedge clk);
    end
    drain();

    // EN again while in ALIGN must be ignored.
    fin0 = n_fin;
    @(negedge clk);
    A = 32'h3F800000; B = 32'h40000000; sub = 1'b0; EN = 1'b1;
    @(negedge clk);
    push_exp(32'h40400000, 5'h00, cyc);
    A = 32'h40000000; B = 32'h40000000;
    check_eq("busy_in_align", 32'(busy), 32'h1);
    @(negedge clk);
    EN = 1'b0;
    repeat (6) @(negedge clk);
    check_eq("ignored_en_finish_count", 32'(n_fin - fin0), 32'd1);
    drain();

    // EN held high: accepted at IDLE and at every DONE, one op per 4 edges.
    fin0 = n_fin;
    @(negedge clk);
    A = 32'h3F800000; B = 32'h3F800000; sub = 1'b0; EN = 1'b1;
    @(negedge clk);
    c0 = cyc;
    push_exp(32'h40000000, 5'h00, c0);
    push_exp(32'h40000000, 5'h00, c0 + 4);
    push_exp(32'h40000000, 5'h00, c0 + 8);
    repeat (8) @(negedge clk);
    EN = 1'b0;
    drain();
    repeat (2) @(negedge clk);
    check_eq("held_en_finish_count", 32'(n_fin - fin0), 32'd3);

    // Reset two edges after issue aborts the op.
    fin0 = n_fin;
    issue(32'h40400000, 32'h3F800000, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_eq("abort_busy", 32'(busy), 32'h0);
    check_eq("abort_finish", 32'(finish), 32'h0);
    check_eq("abort_res", res, 32'h0);
    repeat (6) @(negedge clk);
    check_eq("abort_no_finish", 32'(n_fin - fin0), 32'h0);
    check_eq("abort_res_held", res, 32'h0);

    // Reset wins over a simultaneous EN.
    @(negedge clk);
    A = 32'h3F800000; B = 32'h40000000; sub = 1'b0; EN = 1'b1; rst = 1'b1;
    @(negedge clk);
    EN = 1'b0; rst = 1'b0;
    check_eq("rst_prio_busy", 32'(busy), 32'h0);
    repeat (6) @(negedge clk);
    check_eq("rst_prio_no_finish", 32'(n_fin - fin0), 32'h0);

    check_eq("finish_count", 32'(n_fin), 32'(n_exp));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
